// File: rtl/prio_enc_pkg.sv
// Shared helpers for the pending-request priority encoder: index width
// calculation and index-to-onehot conversion.
package prio_enc_pkg;

    localparam int MAX_N = 256;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Callers truncate the result to their own request width.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        logic [MAX_N-1:0] v;
        v = '0;
        v[idx[7:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Pure combinational priority encoder over an N-bit candidate vector.
// MSB_FIRST selects which end of the vector wins.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int W         = clog2(N)
) (
    input  logic [N-1:0] i_cand,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_cand;
        // The last match written in the loop wins, so the loop runs toward the winning end.
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (i_cand[i]) o_idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i_cand[i]) o_idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_enc_pend.sv
// Edge-captured pending request register with priority selection and a
// valid/ready output register; a presented index holds until accepted.
module prio_enc_pend
    import prio_enc_pkg::*;
#(
    parameter int N          = 8,
    parameter int W          = clog2(N),
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_din,
    input  logic [N-1:0] i_mask,
    input  logic         i_ready,
    output logic [W-1:0] o_dout,
    output logic         o_valid,
    output logic [N-1:0] o_pend,
    output logic         o_ovf
);

    logic [N-1:0] r_din_q;
    logic [N-1:0] r_pend;
    logic [W-1:0] r_dout;
    logic         r_valid;
    logic         r_ovf;

    logic [N-1:0] w_req;
    logic [N-1:0] w_edge;
    logic         w_acc;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_cand;
    logic [W-1:0] w_pick;
    logic         w_any;

    assign w_req  = ACTIVE_LOW ? ~i_din : i_din;
    assign w_edge = w_req & ~r_din_q;
    assign w_acc  = r_valid & i_ready;
    assign w_clr  = w_acc ? N'(onehot(32'(r_dout))) : '0;
    assign w_cand = r_pend & ~w_clr & ~i_mask;

    prio_pick #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST),
        .W         (W)
    ) u_pick (
        .i_cand (w_cand),
        .o_idx  (w_pick),
        .o_any  (w_any)
    );

    // Tracks the lines through reset so a line held across release is not an edge.
    always_ff @(posedge i_clk) begin
        r_din_q <= w_req;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend  <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_edge;
            r_ovf  <= r_ovf | (|(w_edge & r_pend & ~w_clr));
            if (!r_valid || w_acc) begin
                r_valid <= w_any;
                if (w_any) r_dout <= w_pick;
            end
        end
    end

    assign o_dout  = r_dout;
    assign o_valid = r_valid;
    assign o_pend  = r_pend;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_prio_enc_pend.sv
// Directed bench for prio_enc_pend: an MSB-first and an LSB-first instance
// share the same stimulus; expected values are hand-derived per step.
module tb_prio_enc_pend;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [7:0] mask;
    logic       ready;

    logic [2:0] m_dout, l_dout;
    logic       m_valid, l_valid;
    logic [7:0] m_pend, l_pend;
    logic       m_ovf, l_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    prio_enc_pend #(.N(8), .ACTIVE_LOW(1'b1), .MSB_FIRST(1'b1)) dut_msb (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_mask(mask), .i_ready(ready),
        .o_dout(m_dout), .o_valid(m_valid), .o_pend(m_pend), .o_ovf(m_ovf)
    );

    prio_enc_pend #(.N(8), .ACTIVE_LOW(1'b1), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_mask(mask), .i_ready(ready),
        .o_dout(l_dout), .o_valid(l_valid), .o_pend(l_pend), .o_ovf(l_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst   = 1'b1;
        din   = 8'hFF;
        mask  = 8'h00;
        ready = 1'b0;
        tick();
        tick();
        check("rst_pend",  32'(m_pend),  32'h00);
        check("rst_dout",  32'(m_dout),  32'h0);
        check("rst_valid", 32'(m_valid), 32'h0);
        check("rst_ovf",   32'(m_ovf),   32'h0);
        rst = 1'b0;
        tick();

        // Single request on bit 7, held while READY is low.
        din = 8'h7F;
        tick();
        check("t1_pend",  32'(m_pend),  32'h80);
        check("t1_valid0", 32'(m_valid), 32'h0);
        din = 8'hFF;
        tick();
        check("t1_valid", 32'(m_valid), 32'h1);
        check("t1_dout",  32'(m_dout),  32'h7);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_hold_dout",  32'(m_dout),  32'h7);
            check("t1_hold_valid", 32'(m_valid), 32'h1);
        end
        ready = 1'b1;
        tick();
        check("t1_acc_valid", 32'(m_valid), 32'h0);
        check("t1_acc_pend",  32'(m_pend),  32'h00);

        // Bits 7,5,2,0 at once, drained back to back in both priority orders.
        din = 8'h5A;
        tick();
        check("t2_pend", 32'(m_pend), 32'hA5);
        din = 8'hFF;
        tick();
        check("t2_m0", 32'(m_dout), 32'h7); check("t2_l0", 32'(l_dout), 32'h0);
        check("t2_v0", 32'(m_valid & l_valid), 32'h1);
        tick();
        check("t2_m1", 32'(m_dout), 32'h5); check("t2_l1", 32'(l_dout), 32'h2);
        check("t2_pend1", 32'(m_pend), 32'h25);
        tick();
        check("t2_m2", 32'(m_dout), 32'h2); check("t2_l2", 32'(l_dout), 32'h5);
        tick();
        check("t2_m3", 32'(m_dout), 32'h0); check("t2_l3", 32'(l_dout), 32'h7);
        check("t2_v3", 32'(m_valid & l_valid), 32'h1);
        tick();
        check("t2_m_end_valid", 32'(m_valid), 32'h0);
        check("t2_l_end_valid", 32'(l_valid), 32'h0);
        check("t2_m_end_pend",  32'(m_pend),  32'h00);
        check("t2_l_end_pend",  32'(l_pend),  32'h00);

        // Second edge on a pending, presented bit sets sticky overflow.
        ready = 1'b0;
        din = 8'hF7;
        tick();
        din = 8'hFF;
        tick();
        check("t3_dout", 32'(m_dout), 32'h3);
        check("t3_ovf0", 32'(m_ovf),  32'h0);
        din = 8'hF7;
        tick();
        check("t3_ovf1", 32'(m_ovf), 32'h1);
        din = 8'hFF;
        for (int i = 0; i < 100; i++) tick();
        check("t3_ovf_100", 32'(m_ovf), 32'h1);
        ready = 1'b1;
        tick();
        check("t3_acc_valid", 32'(m_valid), 32'h0);
        check("t3_ovf_acc",   32'(m_ovf),   32'h1);
        rst = 1'b1;
        tick();
        check("t3_ovf_rst", 32'(m_ovf), 32'h0);
        rst = 1'b0;
        tick();

        // Accept of index 4 coincides with a new edge on bit 4: set wins.
        ready = 1'b0;
        din = 8'hEF;
        tick();
        din = 8'hFF;
        tick();
        check("t4_dout", 32'(m_dout), 32'h4);
        din = 8'hEF;
        ready = 1'b1;
        tick();
        check("t4_pend", 32'(m_pend), 32'h10);
        check("t4_ovf",  32'(m_ovf),  32'h0);
        check("t4_gap_valid", 32'(m_valid), 32'h0);
        din = 8'hFF;
        ready = 1'b0;
        tick();
        check("t4_re_valid", 32'(m_valid), 32'h1);
        check("t4_re_dout",  32'(m_dout),  32'h4);
        ready = 1'b1;
        tick();
        check("t4_end_pend", 32'(m_pend), 32'h00);

        // Masked bit 7 waits behind bit 1, then released by dropping MASK.
        ready = 1'b0;
        mask = 8'h80;
        din = 8'h7D;
        tick();
        check("t5_pend", 32'(m_pend), 32'h82);
        din = 8'hFF;
        tick();
        check("t5_dout1", 32'(m_dout), 32'h1);
        ready = 1'b1;
        tick();
        check("t5_valid0", 32'(m_valid), 32'h0);
        check("t5_pend80", 32'(m_pend),  32'h80);
        tick();
        check("t5_still_masked", 32'(m_valid), 32'h0);
        mask = 8'h00;
        tick();
        check("t5_valid1", 32'(m_valid), 32'h1);
        check("t5_dout7",  32'(m_dout),  32'h7);
        tick();
        check("t5_end_pend", 32'(m_pend), 32'h00);

        // Line held active through reset is not captured; a fresh edge is.
        ready = 1'b0;
        din = 8'hBF;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t6_pend0",  32'(m_pend),  32'h00);
        check("t6_valid0", 32'(m_valid), 32'h0);
        tick();
        check("t6_pend0b", 32'(m_pend), 32'h00);
        din = 8'hFF;
        tick();
        din = 8'hBF;
        tick();
        check("t6_pend40", 32'(m_pend), 32'h40);
        din = 8'hFF;
        tick();
        check("t6_valid", 32'(m_valid), 32'h1);
        check("t6_dout",  32'(m_dout),  32'h6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prio_enc_pend.md
Name: prio_enc_pend

Overview:
- Parametrised, registered successor to the team's 8-to-3 priority encoder.
- Captures request edges on an N-bit input (polarity selectable) into a pending register.
- Presents the highest-priority unmasked pending index on a valid/ready output handshake, and clears each bit when it is accepted.
- Sits between raw event/interrupt lines and a single consumer such as a sequencer or CPU, which services requests one at a time.

Parameters:
- N, 8: number of request lines; N >= 2.
- W, $clog2(N): index width; derived, do not override.
- ACTIVE_LOW, 1: 1 = DIN bit asserted when 0; 0 = asserted when 1.
- MSB_FIRST, 1: 1 = highest index has priority; 0 = lowest index has priority.

Ports:
- CLK, input, 1: clock, rising edge.
- RST, input, 1: synchronous reset, active-high.
- DIN, input, N: raw request lines, polarity per ACTIVE_LOW.
- MASK, input, N: 1 = bit excluded from selection; the bit is still captured into PEND.
- READY, input, 1: consumer accepts DOUT this cycle.
- DOUT, output, W: index of the selected request.
- VALID, output, 1: DOUT holds a pending, unaccepted request.
- PEND, output, N: pending register, registered.
- OVF, output, 1: sticky flag; a request edge arrived on a bit that was already pending.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Normalisation: req = ACTIVE_LOW ? ~DIN : DIN.
- Previous-sample register: din_q <= req every cycle, including while RST=1.
- Edge detection: edge = req & ~din_q. A line held asserted through reset release is not captured.
- Reset values: PEND=0, DOUT=0, VALID=0, OVF=0.
- Accept condition: acc = VALID & READY.
- Clear mask: clr = acc ? onehot(DOUT) : 0.
- PEND update: PEND <= (PEND & ~clr) | edge. When a new edge and a clear hit the same bit in the same cycle, the set wins and the event is retained.
- OVF update: OVF <= OVF | |(edge & PEND & ~clr). Only RST clears OVF.
- Candidate set: cand = PEND & ~clr & ~MASK.
- Selection: pick = priority select over cand per MSB_FIRST; any = |cand.
- Output register load: when !VALID or acc, load VALID <= any; if any, also load DOUT <= pick.
- Output hold: while VALID & !READY, DOUT and VALID hold.
  - No preemption: a higher-priority arrival waits.
  - Setting MASK on the presented bit does not retract it.
- DOUT retains its last value while VALID=0.
- Latency: DIN asserts before edge k -> PEND bit set after edge k -> VALID/DOUT after edge k+1, assuming the output register is idle or being accepted.
- Throughput: one accept per cycle; with READY held high, back-to-back indices are issued on consecutive cycles.
- Masked bits stay in PEND indefinitely and become selectable the cycle after MASK drops.
- Deasserting DIN does not clear PEND; only acceptance does.
- RST mid-handshake: everything is cleared next cycle and the un-accepted request is lost. The consumer must ignore READY while RST=1.

Decomposition:
- Package prio_enc_pkg holds:
  - the clog2 helper function;
  - the onehot-from-index function.
- One combinational sub-module, prio_pick.
  - Parameters: N, MSB_FIRST.
  - Ports: cand[N-1:0] in; idx[W-1:0] out; any out.
  - Reusable as the generalised pure encoder.
- Everything else (edge detect, PEND, OVF, output register) stays in prio_enc_pend.

Test Plan:
- Reset with ACTIVE_LOW=1 and DIN=8'hFF, release, drive DIN=8'h7F for 1 cycle -> PEND=8'h80 one cycle later; VALID=1 and DOUT=7 one cycle after that. Hold READY=0 for 5 cycles -> DOUT stays 7.
- Drive DIN=8'h5A (bits 7,5,2,0 active) in one cycle with READY=1 and MSB_FIRST=1 -> DOUT sequence 7,5,2,0 on consecutive cycles, then VALID=0 and PEND=0. Same stimulus with MSB_FIRST=0 -> sequence 0,2,5,7.
- Bit 3 pending; pulse a second edge on bit 3 while VALID=1 and READY=0 -> OVF=1, remaining 1 after 100 cycles and through accepts, cleared only by RST.
- Accept DOUT=4 in the same cycle a new edge arrives on bit 4 -> PEND[4] remains 1 and DOUT=4 is re-presented next cycle with OVF=0.
- MASK=8'h80 with bits 7 and 1 pending -> DOUT=1 first. After accepting it, VALID=0 while PEND=8'h80; drop MASK -> VALID=1 with DOUT=7 next cycle.
- Hold DIN bit 6 active while asserting RST for 2 cycles, then release with the line still active -> PEND stays 0 and no VALID. Deassert and reassert bit 6 -> captured normally.
